// File: rtl/trap_seq_pkg.sv
// Shared types and constants for the trapezoid command sequencer.
// Descriptor layout: {yd, yu, xdr, xdl, xur, xul}, each COORD_W bits, xul in the LSBs.
package trap_seq_pkg;

  localparam int COORD_W = 8;
  localparam int DESC_W  = 48;

  localparam int XUL_LSB = 0;
  localparam int XUR_LSB = 8;
  localparam int XDL_LSB = 16;
  localparam int XDR_LSB = 24;
  localparam int YU_LSB  = 32;
  localparam int YD_LSB  = 40;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [DESC_W-1:0]  desc_t;

  // Each state names what nt/xi/yi carry during that cycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_V0,
    S_V1,
    S_V2,
    S_V3,
    S_WAIT
  } state_t;

  // Extract one coordinate from a packed descriptor.
  function automatic coord_t desc_field(input desc_t d, input int lsb);
    return d[lsb +: COORD_W];
  endfunction

endpackage

// File: rtl/trap_desc_fifo.sv
// Synchronous descriptor FIFO; read data is the head entry (no write-to-read bypass).
module trap_desc_fifo
  import trap_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  desc_t            din,
  input  logic             pop,
  output desc_t            dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  desc_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_en;
  logic           pop_en;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write.
  // NOTE: the storage array has no reset; pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves level unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trap_seq_feeder.sv
// Trapezoid command sequencer: buffers descriptors and replays them onto the
// core's 4-cycle nt/xi/yi load protocol, pulsing done when the core goes idle.
// Optional feature macro: TRAP_SEQ_PERF_EN adds the pix_cnt pixel counter.
module trap_seq_feeder
  import trap_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_xul,
  input  logic [7:0]       s_xur,
  input  logic [7:0]       s_xdl,
  input  logic [7:0]       s_xdr,
  input  logic [7:0]       s_yu,
  input  logic [7:0]       s_yd,
  output logic             nt,
  output logic [7:0]       xi,
  output logic [7:0]       yi,
  input  logic             busy,
  input  logic             po,
  output logic             done,
  output logic             idle,
  output logic [LVL_W-1:0] fifo_level
`ifdef TRAP_SEQ_PERF_EN
  ,
  output logic [15:0]      pix_cnt
`endif
);

  state_t state;
  state_t state_next;
  desc_t  work;
  desc_t  work_next;
  desc_t  fifo_dout;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   nt_next;
  coord_t xi_next;
  coord_t yi_next;

  trap_desc_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s_valid),
    .din   ({s_yd, s_yu, s_xdr, s_xdl, s_xur, s_xul}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign s_ready = !fifo_full;
  assign idle    = fifo_empty && (state == S_IDLE);
  assign done    = (state == S_WAIT) && !busy;

  // Next-state logic; a pop happens on every transition into S_V0.
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && !busy) begin
          state_next = S_V0;
          pop        = 1'b1;
        end
      end
      S_V0:   state_next = S_V1;
      S_V1:   state_next = S_V2;
      S_V2:   state_next = S_V3;
      S_V3:   state_next = S_WAIT;
      S_WAIT: begin
        if (!busy) begin
          if (!fifo_empty) begin
            state_next = S_V0;
            pop        = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, taken from the state being entered.
  always_comb begin
    work_next = pop ? fifo_dout : work;
    nt_next   = 1'b0;
    xi_next   = '0;
    yi_next   = '0;
    case (state_next)
      S_V0: begin
        nt_next = 1'b1;
        xi_next = desc_field(work_next, XUL_LSB);
        yi_next = desc_field(work_next, YU_LSB);
      end
      S_V1: xi_next = desc_field(work_next, XUR_LSB);
      S_V2: begin
        xi_next = desc_field(work_next, XDL_LSB);
        yi_next = desc_field(work_next, YD_LSB);
      end
      S_V3:    xi_next = desc_field(work_next, XDR_LSB);
      default: ;
    endcase
  end

  // State, working descriptor and registered core-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      work  <= '0;
      nt    <= 1'b0;
      xi    <= '0;
      yi    <= '0;
    end else begin
      state <= state_next;
      work  <= work_next;
      nt    <= nt_next;
      xi    <= xi_next;
      yi    <= yi_next;
    end
  end

`ifdef TRAP_SEQ_PERF_EN
  // Pixel counter: cleared on entry to S_V0, counts po while a trapezoid is active, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt <= '0;
    end else if (state_next == S_V0) begin
      pix_cnt <= '0;
    end else if ((state != S_IDLE) && po && (pix_cnt != 16'hFFFF)) begin
      pix_cnt <= pix_cnt + 16'd1;
    end
  end
`else
  logic unused_po;
  assign unused_po = po;
`endif

endmodule

// File: tb/tb_trap_seq_feeder.sv
// Self-checking bench for trap_seq_feeder: table of single-descriptor loads plus
// hand-written overflow, back-to-back, push-while-pop, reset and pixel-count sequences.
module tb_trap_seq_feeder;

  typedef struct packed {
    logic [7:0] xul, xur, xdl, xdr, yu, yd;
  } d_t;

  typedef struct packed {
    d_t             d;
    logic [3:0][7:0] exp_xi;
    logic [3:0][7:0] exp_yi;
    logic [7:0]     hold;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_xul, s_xur, s_xdl, s_xdr, s_yu, s_yd;
  logic       nt;
  logic [7:0] xi, yi;
  logic       busy;
  logic       po;
  logic       done;
  logic       idle;
  logic [2:0] fifo_level;
`ifdef TRAP_SEQ_PERF_EN
  logic [15:0] pix_cnt;
`endif

  int total = 0;
  int bad   = 0;

  trap_seq_feeder #(.DEPTH(4), .LVL_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_xul      (s_xul),
    .s_xur      (s_xur),
    .s_xdl      (s_xdl),
    .s_xdr      (s_xdr),
    .s_yu       (s_yu),
    .s_yd       (s_yd),
    .nt         (nt),
    .xi         (xi),
    .yi         (yi),
    .busy       (busy),
    .po         (po),
    .done       (done),
    .idle       (idle),
    .fifo_level (fifo_level)
`ifdef TRAP_SEQ_PERF_EN
    ,
    .pix_cnt    (pix_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_desc(input d_t d);
    s_xul = d.xul; s_xur = d.xur; s_xdl = d.xdl;
    s_xdr = d.xdr; s_yu  = d.yu;  s_yd  = d.yd;
  endtask

  task automatic push(input d_t d);
    drive_desc(d);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  function automatic d_t mk(input int i);
    d_t d;
    d.xul = 8'(8'h40 + i); d.xur = 8'(8'h50 + i); d.xdl = 8'(8'h60 + i);
    d.xdr = 8'(8'h70 + i); d.yu  = 8'(8'h80 + i); d.yd  = 8'(8'h90 + i);
    return d;
  endfunction

  // Advance until nt is seen, bounded; n = negedges waited.
  task automatic wait_nt(output int n);
    n = 0;
    while (nt !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("nt_timeout", 32'(nt), 32'd1);
  endtask

  // Called at the negedge of the S_V0 cycle; ends in the done cycle with busy released.
  task automatic load_seq(input string tag, input logic [3:0][7:0] ex,
                          input logic [3:0][7:0] ey, input int hold);
    int seen;
    check({tag, "_v0_nt"}, 32'(nt), 32'd1);
    check({tag, "_v0_xi"}, 32'(xi), 32'(ex[0]));
    check({tag, "_v0_yi"}, 32'(yi), 32'(ey[0]));
    busy = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("%s_v%0d_nt", tag, k), 32'(nt), 32'd0);
      check($sformatf("%s_v%0d_xi", tag, k), 32'(xi), 32'(ex[k]));
      check($sformatf("%s_v%0d_yi", tag, k), 32'(yi), 32'(ey[k]));
    end
    @(negedge clk);
    check({tag, "_wait_xi"}, 32'(xi), 32'd0);
    check({tag, "_wait_done"}, 32'(done), 32'd0);
    seen = 0;
    repeat (hold) begin
      @(negedge clk);
      if (done) seen++;
    end
    check({tag, "_done_early"}, 32'(seen), 32'd0);
    busy = 1'b0;
    #1;
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic expect_load(input string tag, input d_t d, input int hold);
    load_seq(tag, {d.xdr, d.xdl, d.xur, d.xul}, {8'd0, d.yd, 8'd0, d.yu}, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [3];
    int   n;
    int   stray;
    d_t   a, b, c;

    vecs[0].d      = '{xul: 8'd10, xur: 8'd20, xdl: 8'd5, xdr: 8'd25, yu: 8'd30, yd: 8'd10};
    vecs[0].exp_xi = {8'd25, 8'd5, 8'd20, 8'd10};
    vecs[0].exp_yi = {8'd0, 8'd10, 8'd0, 8'd30};
    vecs[0].hold   = 8'd50;
    vecs[1].d      = '{xul: 8'hFF, xur: 8'h80, xdl: 8'h00, xdr: 8'h7F, yu: 8'hFF, yd: 8'h01};
    vecs[1].exp_xi = {8'h7F, 8'h00, 8'h80, 8'hFF};
    vecs[1].exp_yi = {8'h00, 8'h01, 8'h00, 8'hFF};
    vecs[1].hold   = 8'd0;
    vecs[2].d      = '{xul: 8'h12, xur: 8'h34, xdl: 8'h56, xdr: 8'h78, yu: 8'h9A, yd: 8'hBC};
    vecs[2].exp_xi = {8'h78, 8'h56, 8'h34, 8'h12};
    vecs[2].exp_yi = {8'h00, 8'hBC, 8'h00, 8'h9A};
    vecs[2].hold   = 8'd3;

    reset = 1'b1; s_valid = 1'b0; busy = 1'b0; po = 1'b0;
    drive_desc('0);
    repeat (2) @(negedge clk);
    check("rst_nt", 32'(nt), 32'd0);
    check("rst_xi", 32'(xi), 32'd0);
    check("rst_yi", 32'(yi), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
`ifdef TRAP_SEQ_PERF_EN
    check("rst_pix", 32'(pix_cnt), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Table: one descriptor at a time into an idle sequencer.
    for (int i = 0; i < 3; i++) begin
      push(vecs[i].d);
      check($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'd1);
      check($sformatf("tbl%0d_nt_pre", i), 32'(nt), 32'd0);
      @(negedge clk);
      load_seq($sformatf("tbl%0d", i), vecs[i].exp_xi, vecs[i].exp_yi, int'(vecs[i].hold));
      @(negedge clk);
      check($sformatf("tbl%0d_done_once", i), 32'(done), 32'd0);
      check($sformatf("tbl%0d_idle", i), 32'(idle), 32'd1);
      check($sformatf("tbl%0d_nt_post", i), 32'(nt), 32'd0);
    end

    // Overflow: five pushes against a busy core; the fifth is dropped.
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_desc(mk(i));
      s_valid = 1'b1;
      check($sformatf("ovf%0d_ready", i), 32'(s_ready), (i < 4) ? 32'd1 : 32'd0);
      @(negedge clk);
      check($sformatf("ovf%0d_level", i), 32'(fifo_level), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    s_valid = 1'b0;
    busy    = 1'b0;
    // Back-to-back: each nt comes exactly one cycle after busy drops.
    for (int i = 0; i < 4; i++) begin
      wait_nt(n);
      check($sformatf("b2b%0d_gap", i), 32'(n), 32'd1);
      expect_load($sformatf("b2b%0d", i), mk(i), 2);
    end
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (nt) stray++;
    end
    check("ovf_fifth_dropped", 32'(stray), 32'd0);
    check("ovf_idle", 32'(idle), 32'd1);
    check("ovf_level", 32'(fifo_level), 32'd0);

    // Push while popping at level 2: level holds, order preserved.
    a = mk(8); b = mk(9); c = mk(10);
    busy = 1'b1;
    push(a);
    push(b);
    check("pp_level2", 32'(fifo_level), 32'd2);
    drive_desc(c);
    s_valid = 1'b1;
    busy    = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    check("pp_level_hold", 32'(fifo_level), 32'd2);
    expect_load("pp_a", a, 1);
    @(negedge clk);
    expect_load("pp_b", b, 1);
    @(negedge clk);
    expect_load("pp_c", c, 1);
    @(negedge clk);
    check("pp_idle", 32'(idle), 32'd1);

    // Reset during S_V2 aborts the load and flushes the queue.
    a = mk(16); b = mk(17);
    push(a);
    push(b);
    check("rs_v0_nt", 32'(nt), 32'd1);
    check("rs_level", 32'(fifo_level), 32'd1);
    busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rs_v2_xi", 32'(xi), 32'(a.xdl));
    reset = 1'b1;
    #1;
    check("rs_nt", 32'(nt), 32'd0);
    check("rs_xi", 32'(xi), 32'd0);
    check("rs_yi", 32'(yi), 32'd0);
    check("rs_level0", 32'(fifo_level), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    busy  = 1'b0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (nt || done) stray++;
    end
    check("rs_quiet", 32'(stray), 32'd0);
    c = mk(20);
    push(c);
    @(negedge clk);
    expect_load("rs_after", c, 2);
    @(negedge clk);
    check("rs_idle", 32'(idle), 32'd1);

`ifdef TRAP_SEQ_PERF_EN
    // Pixel counter: 37 po cycles inside one render.
    a = mk(24);
    push(a);
    @(negedge clk);
    check("pix_v0_clear", 32'(pix_cnt), 32'd0);
    check("pix_v0_nt", 32'(nt), 32'd1);
    busy = 1'b1;
    po   = 1'b1;
    repeat (37) @(negedge clk);
    po = 1'b0;
    repeat (3) @(negedge clk);
    busy = 1'b0;
    #1;
    check("pix_done", 32'(done), 32'd1);
    @(negedge clk);
    check("pix_final", 32'(pix_cnt), 32'd37);
    repeat (3) @(negedge clk);
    check("pix_hold", 32'(pix_cnt), 32'd37);
    b = mk(25);
    push(b);
    @(negedge clk);
    check("pix_clear", 32'(pix_cnt), 32'd0);
    expect_load("pix_next", b, 1);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
